// File: rtl/sub_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package sub_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out of this bit.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial subtractor: one bit per clock LSB first, results published only
// when the last bit is processed and held until the next operation completes.
module serial_sub_8 #(
    parameter int WIDTH = sub_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             ZERO,
    output logic             OVF
);

    import sub_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_next;

    full_sub u_full_sub (
        .a    (r_a[r_cnt]),
        .b    (r_b[r_cnt]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last       = (r_cnt == LAST_BIT);
    assign w_shift_next = {w_d, r_shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_shift  <= w_shift_next[WIDTH-1:1];
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    // The final bit goes straight to the outputs so partial sums never show.
                    if (w_last) begin
                        r_diff <= w_shift_next;
                        r_bout <= w_bout;
                        r_zero <= (w_shift_next == '0);
                        r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d != r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign DIFF = r_diff;
    assign Bout = r_bout;
    assign ZERO = r_zero;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench for serial_sub_8 against an arithmetic reference model.
module tb_serial_sub_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Bin = 1'b0;
    logic       busy, done, Bout, ZERO, OVF;
    logic [7:0] DIFF;

    int n_checks = 0;
    int n_errors = 0;

    serial_sub_8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .DIFF  (DIFF),
        .Bout  (Bout),
        .ZERO  (ZERO),
        .OVF   (OVF)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, zero, bout, diff} from plain integer arithmetic.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int u;
        int sa;
        int sb;
        int s;
        logic [7:0] d;
        logic bo, z, ov;
        u  = int'(a) - int'(b) - int'(bin);
        d  = u[7:0];
        bo = (int'(a) < int'(b) + int'(bin));
        sa = $signed(a);
        sb = $signed(b);
        s  = sa - sb - int'(bin);
        ov = (s < -128) || (s > 127);
        z  = (d == 8'h00);
        return {ov, z, bo, d};
    endfunction

    // Launch one operation, scramble inputs mid-flight, report timing observations.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int busy_bad, output int leak, output int done_len);
        logic [7:0] prev;
        busy_bad = 0;
        leak     = 0;
        lat      = -1;
        done_len = 0;
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        prev = DIFF;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
        if (busy !== 1'b1) busy_bad++;
        if (DIFF !== prev) leak++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1 && k < 8) busy_bad++;
            if (DIFF !== prev) leak++;
        end
        if (lat > 0) begin
            @(negedge clk);
            done_len = (done === 1'b1) ? 2 : 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
        if (DIFF !== 8'h00) begin n_errors++; $display("FAIL reset_diff got %h want 00", DIFF); end
        if (Bout !== 1'b0) begin n_errors++; $display("FAIL reset_bout got %b want 0", Bout); end
        if (ZERO !== 1'b0) begin n_errors++; $display("FAIL reset_zero got %b want 0", ZERO); end
        if (OVF !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", OVF); end
        $display("reset: busy=%b done=%b DIFF=%h Bout=%b ZERO=%b OVF=%b", busy, done, DIFF, Bout, ZERO, OVF);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'h05, 8'h00, 8'h00, 8'h80, 8'h7F, 8'h7F};
        logic [7:0] tb [6] = '{8'h03, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h7F};
        logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] td [6] = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00};
        logic [10:0] exp;
        int lat, bb, lk, dl;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], lat, bb, lk, dl);
            exp = model(ta[i], tb[i], tc[i]);
            n_checks += 7;
            if (DIFF !== td[i]) begin n_errors++; $display("FAIL dir%0d_diff got %h want %h", i, DIFF, td[i]); end
            if (Bout !== exp[8]) begin n_errors++; $display("FAIL dir%0d_bout got %b want %b", i, Bout, exp[8]); end
            if (ZERO !== exp[9]) begin n_errors++; $display("FAIL dir%0d_zero got %b want %b", i, ZERO, exp[9]); end
            if (OVF !== exp[10]) begin n_errors++; $display("FAIL dir%0d_ovf got %b want %b", i, OVF, exp[10]); end
            if (lat !== 8) begin n_errors++; $display("FAIL dir%0d_latency got %0d want 8", i, lat); end
            if (dl !== 1) begin n_errors++; $display("FAIL dir%0d_done_len got %0d want 1", i, dl); end
            if (bb !== 0) begin n_errors++; $display("FAIL dir%0d_busy got %0d bad cycles want 0", i, bb); end
            $display("directed %0d: %h - %h - %b -> DIFF=%h Bout=%b ZERO=%b OVF=%b lat=%0d",
                     i, ta[i], tb[i], tc[i], DIFF, Bout, ZERO, OVF, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic bin;
        logic [10:0] exp;
        int lat, bb, lk, dl;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (i == 0) begin a = 8'h00; b = 8'hFF; bin = 1'b1; end
            run_op(a, b, bin, lat, bb, lk, dl);
            exp = model(a, b, bin);
            repeat (2) @(negedge clk);
            n_checks += 8;
            if (DIFF !== exp[7:0]) begin n_errors++; $display("FAIL rnd%0d_diff got %h want %h", i, DIFF, exp[7:0]); end
            if (Bout !== exp[8]) begin n_errors++; $display("FAIL rnd%0d_bout got %b want %b", i, Bout, exp[8]); end
            if (ZERO !== exp[9]) begin n_errors++; $display("FAIL rnd%0d_zero got %b want %b", i, ZERO, exp[9]); end
            if (OVF !== exp[10]) begin n_errors++; $display("FAIL rnd%0d_ovf got %b want %b", i, OVF, exp[10]); end
            if (lat !== 8) begin n_errors++; $display("FAIL rnd%0d_latency got %0d want 8", i, lat); end
            if (bb !== 0) begin n_errors++; $display("FAIL rnd%0d_busy got %0d bad cycles want 0", i, bb); end
            if (lk !== 0) begin n_errors++; $display("FAIL rnd%0d_diff_leak got %0d changes want 0", i, lk); end
            if (dl !== 1) begin n_errors++; $display("FAIL rnd%0d_done_len got %0d want 1", i, dl); end
            $display("random %0d: %h - %h - %b -> DIFF=%h Bout=%b ZERO=%b OVF=%b", i, a, b, bin, DIFF, Bout, ZERO, OVF);
        end
    endtask

    task automatic test_start_while_busy();
        logic [10:0] exp;
        int dones = 0;
        int first = -1;
        exp = model(8'hC3, 8'h5A, 1'b1);
        @(negedge clk);
        A = 8'hC3; B = 8'h5A; Bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) begin A = 8'h11; B = 8'h22; Bin = 1'b0; start = 1'b1; end
            if (k == 3) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = k;
            end
        end
        n_checks += 3;
        if (dones !== 1) begin n_errors++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
        if (first !== 8) begin n_errors++; $display("FAIL busy_start_latency got %0d want 8", first); end
        if ({OVF, ZERO, Bout, DIFF} !== exp) begin
            n_errors++; $display("FAIL busy_start_result got %h want %h", {OVF, ZERO, Bout, DIFF}, exp);
        end
        $display("start_while_busy: dones=%0d first=%0d DIFF=%h", dones, first, DIFF);
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat, bb, lk, dl;
        @(negedge clk);
        A = 8'h55; B = 8'h22; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done got %b want 0", done); end
        if (DIFF !== 8'h00) begin n_errors++; $display("FAIL midrst_diff got %h want 00", DIFF); end
        if (Bout !== 1'b0) begin n_errors++; $display("FAIL midrst_bout got %b want 0", Bout); end
        if (ZERO !== 1'b0) begin n_errors++; $display("FAIL midrst_zero got %b want 0", ZERO); end
        if (OVF !== 1'b0) begin n_errors++; $display("FAIL midrst_ovf got %b want 0", OVF); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks += 1;
        if (dones !== 0) begin n_errors++; $display("FAIL midrst_spurious_done got %0d want 0", dones); end
        run_op(8'h09, 8'h04, 1'b0, lat, bb, lk, dl);
        n_checks += 2;
        if (DIFF !== 8'h05) begin n_errors++; $display("FAIL midrst_fresh_diff got %h want 05", DIFF); end
        if (lat !== 8) begin n_errors++; $display("FAIL midrst_fresh_latency got %0d want 8", lat); end
        $display("reset_mid: spurious_done=%0d fresh DIFF=%h lat=%0d", dones, DIFF, lat);
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [4];
        logic [7:0] ob [4];
        logic       oc [4];
        logic [10:0] exp;
        int idx = 0;
        int last = -1;
        for (int i = 0; i < 4; i++) begin
            oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 1'($urandom);
        end
        @(negedge clk);
        A = oa[0]; B = ob[0]; Bin = oc[0]; start = 1'b1;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                exp = model(oa[idx], ob[idx], oc[idx]);
                n_checks += 2;
                if ({OVF, ZERO, Bout, DIFF} !== exp) begin
                    n_errors++; $display("FAIL b2b%0d_result got %h want %h", idx, {OVF, ZERO, Bout, DIFF}, exp);
                end
                if (c - last !== ((idx == 0) ? 9 : 10)) begin
                    n_errors++; $display("FAIL b2b%0d_spacing got %0d want %0d", idx, c - last, (idx == 0) ? 9 : 10);
                end
                $display("back_to_back %0d: %h - %h - %b -> DIFF=%h at cycle %0d", idx, oa[idx], ob[idx], oc[idx], DIFF, c);
                last = c;
                idx++;
                if (idx < 4) begin A = oa[idx]; B = ob[idx]; Bin = oc[idx]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks += 1;
        if (idx !== 4) begin n_errors++; $display("FAIL b2b_timeout got %0d results want 4", idx); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_8.md
SERIAL_SUB_8 -- requirements
Module: serial_sub_8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (only 8 is verified).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port A, input, 8 bits: minuend, latched on the accepting edge.
REQ-006 SHALL have port B, input, 8 bits: subtrahend, latched on the accepting edge.
REQ-007 SHALL have port Bin, input, 1 bit: borrow-in, latched on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-010 SHALL have port DIFF, output, 8 bits: result A - B - Bin, modulo 256.
REQ-011 SHALL have port Bout, output, 1 bit: borrow-out; 1 iff unsigned A < B + Bin.
REQ-012 SHALL have port ZERO, output, 1 bit: 1 iff DIFF == 8'h00.
REQ-013 SHALL have port OVF, output, 1 bit: two's-complement signed overflow of the subtraction.

Function
REQ-014 SHALL implement an FSM with three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE with start=1 at edge t0, SHALL latch A, B and Bin, clear the bit counter, and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL process one bit, LSB first: compute the 1-bit full-subtract of a[i], b[i] and the borrow register, shift the result into the DIFF shift register, and update the borrow register.
REQ-017 Exactly 8 SHIFT cycles SHALL occur (edges t1..t8); edge t8 SHALL load Bout, ZERO and OVF and enter DONE.
REQ-018 SHALL hold done=1 for exactly the one cycle following t8; edge t9 SHALL return the FSM to IDLE.
REQ-019 busy SHALL be 1 exactly while in SHIFT (8 cycles); busy and done SHALL never be high together.
REQ-020 OVF SHALL equal (A[7] != B[7]) && (DIFF[7] != A[7]), evaluated on the latched operands.
REQ-021 DIFF, Bout, ZERO and OVF SHALL hold their values from t8 until the next operation's t8; intermediate shift values SHALL NOT be visible on DIFF.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored (no queuing); A, B and Bin changing mid-operation SHALL NOT affect the result.
REQ-023 start=1 held continuously SHALL start back-to-back operations, with the next accept occurring at the edge after the FSM re-enters IDLE.
REQ-024 The bit counter SHALL be 3 bits wide and saturate-free: it wraps 7->0 at t8, coincident with leaving SHIFT.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE with busy=0, done=0, DIFF=8'h00, Bout=0, ZERO=0, OVF=0, counter=0 and borrow register=0.
REQ-026 Reset SHALL take priority over start and SHALL abort an in-flight operation without producing a done pulse.

Structure
REQ-027 The state enum (IDLE, SHIFT, DONE) and the WIDTH constant SHALL live in shared package sub_pkg.
REQ-028 The bitwise step SHALL be a sub-module full_sub (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-029 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-030 Basic subtract: A=8'h05, B=8'h03, Bin=0 -> DIFF=8'h02, Bout=0, ZERO=0, OVF=0; done pulses 8 edges after the accepting edge.
REQ-031 Underflow: A=8'h00, B=8'h01, Bin=0 -> DIFF=8'hFF, Bout=1, OVF=0; and A=8'h00, B=8'h00, Bin=1 -> DIFF=8'hFF, Bout=1.
REQ-032 Signed overflow: A=8'h80, B=8'h01 -> DIFF=8'h7F, OVF=1, Bout=0; and A=8'h7F, B=8'hFF -> DIFF=8'h80, OVF=1, Bout=1.
REQ-033 Zero result: A=8'h7F, B=8'h7F, Bin=0 -> DIFF=8'h00, ZERO=1, Bout=0.
REQ-034 Start while busy: pulse start with new operands at t3 -> ignored; the first result completes unchanged and exactly one done pulse occurs.
REQ-035 Reset mid-operation: assert rst at t4 -> next cycle IDLE with all outputs 0 and no done pulse; then a fresh 8'h09 - 8'h04 -> DIFF=8'h05.
